// File: rtl/ula_pkg.sv
// Shared definitions for the ALU-side blocks built around the 8-bit 74181-style ALU.
//   BYTE_W          : width of one ALU slice
//   ula_seq_state_t : sequencer state (IDLE, EXEC, DONE)
//   ula_op_t        : function select, mode and carry-in of one operation
package ula_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } ula_seq_state_t;

    typedef struct packed {
        logic [3:0] s;     // 74181 function select
        logic       m;     // 1 = logic mode
        logic       c_in;  // carry into byte 0, ALU-native polarity
    } ula_op_t;

endpackage

// File: rtl/ula_sequencial_if.sv
// Request/result channel of the multi-byte ALU sequencer.
//   in_valid/in_ready   : request handshake carrying in_a, in_b, in_s, in_m, in_c_in
//   out_valid/out_ready : result handshake carrying out_f, out_c_out, out_a_eq_b
// master = requester/consumer side, slave = sequencer side.
interface ula_sequencial_if #(
    parameter int N_BYTES = 2
);
    localparam int W = ula_pkg::BYTE_W * N_BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_s;
    logic         in_m;
    logic         in_c_in;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_f;
    logic         out_c_out;
    logic         out_a_eq_b;

    modport master (
        output in_valid, in_a, in_b, in_s, in_m, in_c_in, out_ready,
        input  in_ready, out_valid, out_f, out_c_out, out_a_eq_b
    );

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_m, in_c_in, out_ready,
        output in_ready, out_valid, out_f, out_c_out, out_a_eq_b
    );
endinterface

// File: rtl/ula_sequencial.sv
// Multi-byte operation sequencer feeding an external 8-bit ALU.
// Accepts one wide operation, presents it to the ALU one byte per cycle
// (least significant first), chains the ALU carry between bytes and returns
// the assembled result on a valid/ready channel.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/result channel, see ula_sequencial_if
//   alu_a/b/s/m/c_in: byte and control presented to the ALU (0 outside EXEC)
//   alu_f/c_out/a_eq_b : combinational ALU response for the presented byte
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int N_BYTES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ula_sequencial_if.slave   bus,
    output logic [BYTE_W-1:0] alu_a,
    output logic [BYTE_W-1:0] alu_b,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_c_in,
    input  logic [BYTE_W-1:0] alu_f,
    input  logic              alu_c_out,
    input  logic              alu_a_eq_b
);

    localparam int W     = BYTE_W * N_BYTES;
    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    ula_seq_state_t   state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    ula_op_t          op_reg;
    logic             carry_reg;
    logic             eq_reg;
    logic [W-1:0]     result_reg;
    logic             c_out_reg;
    logic             a_eq_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            carry_reg  <= 1'b0;
            eq_reg     <= 1'b0;
            result_reg <= '0;
            c_out_reg  <= 1'b0;
            a_eq_b_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg   <= EXEC;
                        idx_reg     <= '0;
                        a_reg       <= bus.in_a;
                        b_reg       <= bus.in_b;
                        op_reg.s    <= bus.in_s;
                        op_reg.m    <= bus.in_m;
                        op_reg.c_in <= bus.in_c_in;
                        carry_reg   <= bus.in_c_in;
                        eq_reg      <= 1'b1;
                    end
                end
                EXEC: begin
                    // Carry is chained in both modes; in logic mode the ALU
                    // ignores it, so no special case is needed here.
                    result_reg[idx_reg*BYTE_W +: BYTE_W] <= alu_f;
                    carry_reg <= alu_c_out;
                    eq_reg    <= eq_reg & alu_a_eq_b;
                    if (idx_reg == LAST_IDX) begin
                        state_reg  <= DONE;
                        idx_reg    <= '0;
                        c_out_reg  <= alu_c_out;
                        a_eq_b_reg <= eq_reg & alu_a_eq_b;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    // A consumed result returns to IDLE; the next request can
                    // only be taken on the following edge.
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ALU bus is decoded from registered state only.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_s    = '0;
        alu_m    = 1'b0;
        alu_c_in = 1'b0;
        if (state_reg == EXEC) begin
            alu_a    = a_reg[idx_reg*BYTE_W +: BYTE_W];
            alu_b    = b_reg[idx_reg*BYTE_W +: BYTE_W];
            alu_s    = op_reg.s;
            alu_m    = op_reg.m;
            alu_c_in = carry_reg;
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.out_f      = result_reg;
    assign bus.out_c_out  = c_out_reg;
    assign bus.out_a_eq_b = a_eq_b_reg;

endmodule

// File: tb/tb_ula_sequencial.sv
module tb_ula_sequencial;

    localparam int N  = 2;
    localparam int W  = 8 * N;
    localparam int W4 = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // External 74181 ALU (active-high data, active-low carry pins).
    function automatic logic [9:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
        logic [7:0] x, y, f;
        logic [8:0] sum;
        x   = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        y   = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {8'd0, ~cn};
        f   = m ? ~(x ^ y) : sum[7:0];
        return {&f, ~sum[8], f};
    endfunction

    // Reference: the whole wide operation computed at once -> {eq, c_out, f}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] s, input logic m, input logic cn);
        logic [W-1:0] x, y, f;
        logic [W:0]   sum;
        x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        y   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cn};
        f   = m ? ~(x ^ y) : sum[W-1:0];
        return {&f, ~sum[W], f};
    endfunction

    // ---------------- 2-byte DUT ----------------
    ula_sequencial_if #(.N_BYTES(N)) bus ();
    logic [7:0] alu_a, alu_b, alu_f;
    logic [3:0] alu_s;
    logic       alu_m, alu_c_in, alu_c_out, alu_a_eq_b;

    ula_sequencial #(.N_BYTES(N)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_c_in   (alu_c_in),
        .alu_f      (alu_f),
        .alu_c_out  (alu_c_out),
        .alu_a_eq_b (alu_a_eq_b)
    );
    always_comb {alu_a_eq_b, alu_c_out, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_c_in);

    // ---------------- 4-byte DUT ----------------
    ula_sequencial_if #(.N_BYTES(4)) bus4 ();
    logic [7:0] alu4_a, alu4_b, alu4_f;
    logic [3:0] alu4_s;
    logic       alu4_m, alu4_c_in, alu4_c_out, alu4_a_eq_b;

    ula_sequencial #(.N_BYTES(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus4.slave),
        .alu_a      (alu4_a),
        .alu_b      (alu4_b),
        .alu_s      (alu4_s),
        .alu_m      (alu4_m),
        .alu_c_in   (alu4_c_in),
        .alu_f      (alu4_f),
        .alu_c_out  (alu4_c_out),
        .alu_a_eq_b (alu4_a_eq_b)
    );
    always_comb {alu4_a_eq_b, alu4_c_out, alu4_f} = alu181(alu4_a, alu4_b, alu4_s, alu4_m, alu4_c_in);

    // ---------------- cycle-level compare process (2-byte DUT) ----------------
    // phase 0 = idle, 1..N = byte phase-1 on the ALU bus, N+1 = result held.
    int             phase = 0;
    logic [W-1:0]   cur_a, cur_b;
    logic [3:0]     cur_s;
    logic           cur_m, cur_cn;
    logic [W+1:0]   cur_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0;
        end else begin
            if (phase == 0) begin
                chk("idle_hs", {bus.in_ready, bus.out_valid}, 2'b10);
                chk("idle_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, '0);
            end else if (phase <= N) begin
                chk("exec_hs", {bus.in_ready, bus.out_valid}, 2'b00);
                chk("exec_alu_a", alu_a, cur_a[(phase-1)*8 +: 8]);
                chk("exec_alu_b", alu_b, cur_b[(phase-1)*8 +: 8]);
                chk("exec_alu_sm", {alu_s, alu_m}, {cur_s, cur_m});
                if (phase == 1) chk("exec_alu_cin0", alu_c_in, cur_cn);
            end else begin
                chk("done_hs", {bus.in_ready, bus.out_valid}, 2'b01);
                chk("done_f", bus.out_f, cur_exp[W-1:0]);
                chk("done_cout", bus.out_c_out, cur_exp[W]);
                chk("done_eq", bus.out_a_eq_b, cur_exp[W+1]);
                chk("done_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, '0);
            end
            // advance the expected phase for the coming edge
            if (phase == 0) begin
                if (bus.in_valid) begin
                    cur_a   = bus.in_a;
                    cur_b   = bus.in_b;
                    cur_s   = bus.in_s;
                    cur_m   = bus.in_m;
                    cur_cn  = bus.in_c_in;
                    cur_exp = model_op(cur_a, cur_b, cur_s, cur_m, cur_cn);
                    phase   = 1;
                end
            end else if (phase <= N) begin
                phase = phase + 1;
            end else if (bus.out_ready) begin
                phase = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cn, input int hold,
                         output logic [W+1:0] res, output int lat);
        @(posedge clk); #1;
        bus.in_a = a; bus.in_b = b; bus.in_s = s; bus.in_m = m; bus.in_c_in = cn;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", bus.out_valid, 1'b1);
        res = {bus.out_a_eq_b, bus.out_c_out, bus.out_f};
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                bus.in_a = ~a;
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk("bp_stable_f", bus.out_f, res[W-1:0]);
            chk("bp_hs", {bus.in_ready, bus.out_valid}, 2'b01);
        end
        if (hold > 0) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_release_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        end
    endtask

    initial begin
        logic [W+1:0] res;
        int           lat;
        logic [W-1:0] ra, rb;
        int           lat4;

        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_s = 0; bus.in_m = 0; bus.in_c_in = 0;
        bus.out_ready = 1'b1;
        bus4.in_valid = 0; bus4.in_a = 0; bus4.in_b = 0; bus4.in_s = 0; bus4.in_m = 0; bus4.in_c_in = 0;
        bus4.out_ready = 1'b1;
        #1;
        chk("rst_hs", {bus.in_ready, bus.out_valid}, 2'b10);
        chk("rst_out", {bus.out_f, bus.out_c_out, bus.out_a_eq_b}, '0);
        chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // model pins
        res = model_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        chk("model_add", res[W-1:0], 16'h0100);
        res = model_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1);
        chk("model_sub_eq", {res[W+1], res[W-1:0]}, {1'b1, 16'hFFFF});
        res = model_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0);
        chk("model_xor", res[W-1:0], 16'h5A5A);

        // add with carry across bytes, latency
        do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, res, lat);
        chk("add_f", res[W-1:0], 16'h0100);
        chk("add_cout", res[W], 1'b1);
        chk("add_lat", lat, N + 1);

        // subtract compare
        do_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 0, res, lat);
        chk("sub_eq_f", res[W-1:0], 16'hFFFF);
        chk("sub_eq_flag", res[W+1], 1'b1);
        do_op(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 0, res, lat);
        chk("sub_neq_f", res[W-1:0], 16'hFFFE);
        chk("sub_neq_flag", res[W+1], 1'b0);

        // logic XOR, both carry levels; second one under backpressure
        do_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1, 0, res, lat);
        chk("xor_cn1_f", res[W-1:0], 16'h5A5A);
        do_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 5, res, lat);
        chk("xor_cn0_f", res[W-1:0], 16'h5A5A);

        // reset during byte 0
        @(posedge clk); #1;
        bus.in_a = 16'hBEEF; bus.in_b = 16'h1357; bus.in_s = 4'b1001; bus.in_m = 0; bus.in_c_in = 1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_hs", {bus.in_ready, bus.out_valid}, 2'b10);
        chk("arst_out", {bus.out_f, bus.out_c_out, bus.out_a_eq_b}, '0);
        chk("arst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, res, lat);
        chk("post_rst_f", res[W-1:0], 16'h0100);

        // randomized operations, checked by the compare process
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            do_op(ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), res, lat);
            chk("rand_lat", lat, N + 1);
        end

        // 4-byte build: carry ripples across two byte boundaries
        @(posedge clk); #1;
        bus4.in_a = 32'h0000FFFF; bus4.in_b = 32'h00000001; bus4.in_s = 4'b1001;
        bus4.in_m = 1'b0; bus4.in_c_in = 1'b1; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat4 = 1;
        while (!bus4.out_valid && lat4 < 20) begin
            @(posedge clk); #1;
            lat4++;
        end
        chk("n4_lat", lat4, 5);
        chk("n4_f", bus4.out_f, 32'h00010000);
        chk("n4_cout", bus4.out_c_out, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
